// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server: answers HPS ioctl upload reads with 16-bit words fetched byte-wise from core RAM.
// Ports: clk_sys/reset (sync, active-high); ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ioctl_din, ioctl_wait
// form the hps_io upload handshake; upload_req asks the HPS to start a save, save_trigger requests one;
// ram_addr/ram_rd/ram_q is the core byte RAM port; busy marks a matching session, done pulses at its end.
// Optional UPLOAD_AUTOREQ_EN adds ram_we and vblank: writes mark the RAM dirty and the next vblank rise requests a save.
module ioctl_upload_server #(
    parameter logic [7:0] UPLOAD_INDEX = 8'd4,
    parameter int         ADDR_W       = 10,
    parameter int         DATA_BYTES   = 1024,
    parameter int         RAM_LATENCY  = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [26:0]       ioctl_addr,
    output logic [15:0]       ioctl_din,
    output logic              ioctl_wait,
    output logic              upload_req,
    input  logic              save_trigger,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
`ifdef UPLOAD_AUTOREQ_EN
    input  logic              ram_we,
    input  logic              vblank,
`endif
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT} state_t;
    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic [7:0]        lo, lo_n;
    logic              oor_lo, oor_hi, oor_lo_n, oor_hi_n;
    logic [15:0]       din_n;
    logic              wait_n, rd_n, busy_d, auto_set;
    logic [ADDR_W-1:0] addr_n;
    logic [26:0]       addr_even;
    wire active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign addr_even = ioctl_addr & ~27'd1;
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lo_n     = lo;
        oor_lo_n = oor_lo;
        oor_hi_n = oor_hi;
        din_n    = ioctl_din;
        wait_n   = ioctl_wait;
        rd_n     = 1'b0;
        addr_n   = ram_addr;
        if (!active) begin
            // session lost: drop the fetch, keep the last presented word
            state_n = IDLE;
            wait_n  = 1'b0;
        end else begin
            case (state)
                IDLE: if (ioctl_rd) begin
                    state_n  = LO_REQ;
                    wait_n   = 1'b1;
                    rd_n     = 1'b1;
                    addr_n   = addr_even[ADDR_W-1:0];
                    // range is judged on the full address; ram_addr itself wraps
                    oor_lo_n = addr_even >= 27'(DATA_BYTES);
                    oor_hi_n = addr_even + 27'd1 >= 27'(DATA_BYTES);
                end
                LO_REQ, HI_REQ: begin
                    cnt_n   = 2'(RAM_LATENCY - 1);
                    state_n = state == LO_REQ ? LO_WAIT : HI_WAIT;
                end
                LO_WAIT: if (cnt == 2'd0) begin
                    lo_n    = oor_lo ? 8'hFF : ram_q;
                    addr_n  = ram_addr + 1'b1;
                    rd_n    = 1'b1;
                    state_n = HI_REQ;
                end else
                    cnt_n = cnt - 2'd1;
                HI_WAIT: if (cnt == 2'd0) begin
                    din_n   = {oor_hi ? 8'hFF : ram_q, lo};
                    wait_n  = 1'b0;
                    state_n = IDLE;
                end else
                    cnt_n = cnt - 2'd1;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lo         <= '0;
            oor_lo     <= 1'b0;
            oor_hi     <= 1'b0;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            busy       <= 1'b0;
            busy_d     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lo         <= lo_n;
            oor_lo     <= oor_lo_n;
            oor_hi     <= oor_hi_n;
            ioctl_din  <= din_n;
            ioctl_wait <= wait_n;
            ram_rd     <= rd_n;
            ram_addr   <= addr_n;
            busy       <= active;
            busy_d     <= busy;
            done       <= busy_d && !busy;
        end
    end
`ifdef UPLOAD_AUTOREQ_EN
    logic vblank_q, dirty;
    assign auto_set = vblank && !vblank_q && dirty && !busy;
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vblank_q <= 1'b0;
            dirty    <= 1'b0;
        end else begin
            vblank_q <= vblank;
            // a write racing the clear keeps the RAM marked dirty
            dirty    <= ram_we ? 1'b1 : auto_set ? 1'b0 : dirty;
        end
    end
`else
    assign auto_set = 1'b0;
`endif
    // a session starting means the pending request was served, so busy rise beats a new trigger
    always_ff @(posedge clk_sys) begin
        if (reset)
            upload_req <= 1'b0;
        else if (active && !busy)
            upload_req <= 1'b0;
        else if (!busy && (save_trigger || auto_set))
            upload_req <= 1'b1;
    end
endmodule

// File: tb/tb_ioctl_upload_server.sv
// tb_ioctl_upload_server: directed checks of two ioctl_upload_server configurations against byte[i]=i RAM models.
module tb_ioctl_upload_server;
    logic        clk_sys = 1'b0, reset = 1'b1, ioctl_upload = 1'b0, ioctl_rd = 1'b0, save_trigger = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] din0, din1;
    logic        io_wait0, io_wait1, req0, req1, rd0, rd1, busy0, busy1, done0, done1;
    logic [9:0]  ra0, ra1;
    logic [7:0]  q0, q1, p1, p2;
    int          checks = 0, errors = 0;

    always #5 clk_sys = ~clk_sys;

    // u0: latency 1, last byte 0x3FF out of range; u1: latency 3, only bytes 0..0x10 valid
    ioctl_upload_server #(.DATA_BYTES(1023), .RAM_LATENCY(1)) u0 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din0), .ioctl_wait(io_wait0),
        .upload_req(req0), .save_trigger(save_trigger), .ram_addr(ra0), .ram_rd(rd0), .ram_q(q0),
        .busy(busy0), .done(done0));
    ioctl_upload_server #(.DATA_BYTES(17), .RAM_LATENCY(3)) u1 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(io_wait1),
        .upload_req(req1), .save_trigger(save_trigger), .ram_addr(ra1), .ram_rd(rd1), .ram_q(q1),
        .busy(busy1), .done(done1));

    always @(posedge clk_sys) q0 <= ra0[7:0];
    always @(posedge clk_sys) begin
        p1 <= ra1[7:0];
        p2 <= p1;
        q1 <= p2;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic do_read(input logic [26:0] a, output int w0, output int w1, output int n0, output int n1,
                           output logic [9:0] f0, output logic [9:0] s0, output logic [9:0] f1, output logic [9:0] s1);
        w0 = 0; w1 = 0; n0 = 0; n1 = 0; f0 = 'x; s0 = 'x; f1 = 'x; s1 = 'x;
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            w0 += int'(io_wait0);
            w1 += int'(io_wait1);
            if (rd0) begin
                if (n0 == 0) f0 = ra0; else s0 = ra0;
                n0++;
            end
            if (rd1) begin
                if (n1 == 0) f1 = ra1; else s1 = ra1;
                n1++;
            end
            @(negedge clk_sys);
        end
    endtask

    typedef struct {
        logic [26:0] addr;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [9:0]  ra;
        logic [9:0]  rb;
    } vec_t;
    vec_t v[6];

    task automatic run_vec(input vec_t t);
        int w0, w1, n0, n1;
        logic [9:0] f0, s0, f1, s1;
        do_read(t.addr, w0, w1, n0, n1, f0, s0, f1, s1);
        chk($sformatf("din0@%0h", t.addr), 32'(din0), 32'(t.d0));
        chk($sformatf("din1@%0h", t.addr), 32'(din1), 32'(t.d1));
        chk($sformatf("wait0@%0h", t.addr), w0, 4);
        chk($sformatf("wait1@%0h", t.addr), w1, 8);
        chk($sformatf("rds0@%0h", t.addr), n0, 2);
        chk($sformatf("rds1@%0h", t.addr), n1, 2);
        chk($sformatf("ra_lo0@%0h", t.addr), 32'(f0), 32'(t.ra));
        chk($sformatf("ra_hi0@%0h", t.addr), 32'(s0), 32'(t.rb));
        chk($sformatf("ra_lo1@%0h", t.addr), 32'(f1), 32'(t.ra));
        chk($sformatf("ra_hi1@%0h", t.addr), 32'(s1), 32'(t.rb));
    endtask

    initial begin
        int n, dn;
        v[0] = '{27'h010, 16'h1110, 16'hFF10, 10'h010, 10'h011};
        v[1] = '{27'h3FE, 16'hFFFE, 16'hFFFF, 10'h3FE, 10'h3FF};
        v[2] = '{27'h400, 16'hFFFF, 16'hFFFF, 10'h000, 10'h001};
        v[3] = '{27'h000, 16'h0100, 16'h0100, 10'h000, 10'h001};
        v[4] = '{27'h011, 16'h1110, 16'hFF10, 10'h010, 10'h011};
        v[5] = '{27'h022, 16'h2322, 16'hFFFF, 10'h022, 10'h023};

        repeat (3) @(negedge clk_sys);
        chk("rst_din", 32'(din0), 0);
        chk("rst_wait", 32'(io_wait0), 0);
        chk("rst_req", 32'(req0), 0);
        chk("rst_ram_addr", 32'(ra0), 0);
        chk("rst_ram_rd", 32'(rd0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        reset = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
        repeat (2) @(negedge clk_sys);
        chk("busy_up", 32'(busy0), 1);

        for (int i = 0; i < 6; i++) run_vec(v[i]);

        // wrong index: strobe ignored
        ioctl_index = 8'd3;
        repeat (3) @(negedge clk_sys);
        ioctl_addr = 27'h010;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            n += int'(rd0) + int'(io_wait0) + int'(rd1) + int'(io_wait1);
            @(negedge clk_sys);
        end
        chk("idx3_activity", n, 0);
        chk("idx3_busy", 32'(busy0), 0);
        chk("idx3_din0", 32'(din0), 32'(v[5].d0));

        // upload dropped two cycles after the strobe
        ioctl_index = 8'd4;
        repeat (2) @(negedge clk_sys);
        ioctl_addr = 27'h010;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("abort_wait0", 32'(io_wait0), 0);
        chk("abort_wait1", 32'(io_wait1), 0);
        chk("abort_rd0", 32'(rd0), 0);
        chk("abort_rd1", 32'(rd1), 0);
        chk("abort_din0", 32'(din0), 32'(v[5].d0));
        chk("abort_din1", 32'(din1), 32'(v[5].d1));
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            dn += int'(done0);
        end
        chk("abort_done_pulses", dn, 1);
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        run_vec(v[3]);

        // upload_req handshake
        ioctl_upload = 1'b0;
        repeat (3) @(negedge clk_sys);
        save_trigger = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b0;
        chk("req_set", 32'(req0), 1);
        repeat (3) @(negedge clk_sys);
        chk("req_held", 32'(req0), 1);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("req_busy", 32'(busy0), 1);
        chk("req_clr", 32'(req0), 0);
        save_trigger = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b0;
        chk("req_ignored_busy", 32'(req0), 0);
        ioctl_upload = 1'b0;
        repeat (3) @(negedge clk_sys);
        ioctl_upload = 1'b1;
        save_trigger = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b0;
        chk("req_same_cycle_busy", 32'(busy0), 1);
        chk("req_same_cycle", 32'(req0), 0);

        // reset during u1 HI_WAIT
        repeat (2) @(negedge clk_sys);
        ioctl_addr = 27'h010;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("mid_wait1", 32'(io_wait1), 1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("mid_rst_din1", 32'(din1), 0);
        chk("mid_rst_wait1", 32'(io_wait1), 0);
        chk("mid_rst_ram_addr1", 32'(ra1), 0);
        chk("mid_rst_rd1", 32'(rd1), 0);
        chk("mid_rst_busy1", 32'(busy1), 0);
        chk("mid_rst_done1", 32'(done1), 0);
        chk("mid_rst_req1", 32'(req1), 0);
        chk("mid_rst_din0", 32'(din0), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        run_vec(v[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
